// File: rtl/ula_pkg.sv
// Shared types and named function selects for the sequential slice ALU.
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] S_SOMA = 4'd9;  // A + B (m=0)
  localparam logic [3:0] S_SUB  = 4'd6;  // A - B with c_in=1 (m=0)
  localparam logic [3:0] S_INC  = 4'd0;  // A + c_in (m=0)
  localparam logic [3:0] S_XOR  = 4'd6;  // A ^ B (m=1)

endpackage

// File: rtl/ula_fatia.sv
// Combinational SLICE-bit ALU slice: 16 logic functions (m=1) or X+Y+c_in (m=0).
module ula_fatia #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic [SLICE-1:0] f,
  output logic             c_out,
  output logic             ovf
);

  logic [SLICE-1:0] op_x;
  logic [SLICE-1:0] op_y;
  logic [SLICE:0]   sum;
  logic             carry_into_msb;

  always_comb begin
    op_x = '0;
    op_y = '0;
    case (s)
      4'd0:  begin op_x = x;       op_y = '0;      end
      4'd1:  begin op_x = x | y;   op_y = '0;      end
      4'd2:  begin op_x = x | ~y;  op_y = '0;      end
      4'd3:  begin op_x = '0;      op_y = '1;      end
      4'd4:  begin op_x = x;       op_y = x & ~y;  end
      4'd5:  begin op_x = x | y;   op_y = x & ~y;  end
      4'd6:  begin op_x = x;       op_y = ~y;      end
      4'd7:  begin op_x = x & ~y;  op_y = '1;      end
      4'd8:  begin op_x = x;       op_y = x & y;   end
      4'd9:  begin op_x = x;       op_y = y;       end
      4'd10: begin op_x = x | ~y;  op_y = x & y;   end
      4'd11: begin op_x = x & y;   op_y = '1;      end
      4'd12: begin op_x = x;       op_y = x;       end
      4'd13: begin op_x = x | y;   op_y = x;       end
      4'd14: begin op_x = x | ~y;  op_y = x;       end
      default: begin op_x = x;     op_y = '1;      end
    endcase

    sum            = {1'b0, op_x} + {1'b0, op_y} + (SLICE+1)'(c_in);
    carry_into_msb = op_x[SLICE-1] ^ op_y[SLICE-1] ^ sum[SLICE-1];

    f     = sum[SLICE-1:0];
    c_out = sum[SLICE];
    ovf   = carry_into_msb ^ sum[SLICE];

    if (m) begin
      c_out = 1'b0;
      ovf   = 1'b0;
      case (s)
        4'd0:  f = ~x;
        4'd1:  f = ~(x | y);
        4'd2:  f = ~x & y;
        4'd3:  f = '0;
        4'd4:  f = ~(x & y);
        4'd5:  f = ~y;
        4'd6:  f = x ^ y;
        4'd7:  f = x & ~y;
        4'd8:  f = ~x | y;
        4'd9:  f = ~(x ^ y);
        4'd10: f = y;
        4'd11: f = x & y;
        4'd12: f = '1;
        4'd13: f = x | ~y;
        4'd14: f = x | y;
        default: f = x;
      endcase
    end
  end

endmodule

// File: rtl/ula_n_bits_seq.sv
// WIDTH-bit ALU computed SLICE bits per clock through one reused slice, carry rippled in a register.
// Define ULA_FLAGS_EN to add registered zero and signed-overflow outputs.
module ula_n_bits_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // Both sides: a transfer happens on a rising edge where valid && ready.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b
`ifdef ULA_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d, carry_q, carry_d, c_out_q, c_out_d;
  logic [SLICE-1:0] slice_x, slice_y, slice_f;
  logic             slice_co;
`ifdef ULA_FLAGS_EN
  logic             slice_ovf;
  logic             zero_q, zero_d, ovf_q, ovf_d;
`endif

  ula_fatia #(.SLICE(SLICE)) u_fatia (
    .x     (slice_x),
    .y     (slice_y),
    .s     (s_q),
    .m     (m_q),
    .c_in  (carry_q),
    .f     (slice_f),
    .c_out (slice_co),
`ifdef ULA_FLAGS_EN
    .ovf   (slice_ovf)
`else
    .ovf   ()
`endif
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    carry_d = carry_q;
    f_d     = f_q;
    c_out_d = c_out_q;
`ifdef ULA_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    slice_x = a_q[idx_q*SLICE +: SLICE];
    slice_y = b_q[idx_q*SLICE +: SLICE];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          carry_d = c_in;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        f_d[idx_q*SLICE +: SLICE] = slice_f;
        carry_d = slice_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          c_out_d = m_q ? 1'b0 : slice_co;
          state_d = DONE;
`ifdef ULA_FLAGS_EN
          zero_d  = (f_d == '0);
          ovf_d   = slice_ovf;
`endif
        end
      end
      DONE: begin
        // No accept here: the earliest new accept is the cycle after IDLE is re-entered.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      f_q     <= '0;
      c_out_q <= 1'b0;
`ifdef ULA_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      carry_q <= carry_d;
      f_q     <= f_d;
      c_out_q <= c_out_d;
`ifdef ULA_FLAGS_EN
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign f         = f_q;
  assign c_out     = c_out_q;
  assign a_eq_b    = &f_q;
`ifdef ULA_FLAGS_EN
  assign zero      = zero_q;
  assign ovf       = ovf_q;
`endif

endmodule

// File: doc/ula_n_bits_seq.md
Name: ula_n_bits_seq

Overview:
- Parametrised, multi-cycle successor to the combinational 8-bit ALU.
- Implements the same 16-function, two-mode (m) function set at WIDTH bits.
- Processes operands SLICE bits per clock through one reused slice ALU, rippling the carry through a register.
- Sits between an operand source and a result sink; valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8: operand/result width. Must be a multiple of SLICE.
- SLICE, 4: bits processed per cycle. NSLICES = WIDTH/SLICE.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept an operand set (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- s  input  4  function select.
- m  input  1  1 = logic, 0 = arithmetic.
- c_in  input  1  carry in, active-high (adds 1).
- out_valid  output  1  result held valid.
- out_ready  input  1  sink accepts result.
- f  output  WIDTH  result.
- c_out  output  1  carry out of the MSB; 0 in logic mode.
- a_eq_b  output  1  1 when f is all ones.

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n. FSM states: IDLE, CALC, DONE.
- Reset (any state, including mid-CALC): state=IDLE, out_valid=0, f=0, c_out=0, a_eq_b=0, slice index=0. Any in-flight operation is discarded.
- in_ready = (state==IDLE); combinational, so it is 1 during reset.
- IDLE, in_valid=1:
  - Capture a, b, s, m, c_in into registers.
  - carry_r=c_in, idx=0; go to CALC.
  - Later input changes have no effect.
- CALC, one slice per clock:
  - Slice idx (bits idx*SLICE +: SLICE) is computed with carry_r.
  - Result written into f_r at that slice; carry_r <= slice carry out; idx++.
  - After slice NSLICES-1: go to DONE.
  - c_out = final carry if m=0, else 0.
  - a_eq_b = &f_r.
- DONE:
  - out_valid=1; f, c_out and a_eq_b are held stable.
  - in_valid is ignored.
  - out_valid && out_ready: go to IDLE. No new accept in that same cycle.
- Latency: out_valid rises NSLICES clocks after the accept edge. Minimum period between accepts is NSLICES+2 cycles.
- Logic mode (m=1), bitwise, carry ignored:
  - s0..s3: ~A, ~(A|B), ~A&B, 0
  - s4..s7: ~(A&B), ~B, A^B, A&~B
  - s8..s11: ~A|B, ~(A^B), B, A&B
  - s12..s15: all ones, A|~B, A|B, A
- Arithmetic mode (m=0): F = X + Y + carry, with (X, Y) per s ("1s" = all ones):
  - s0..s3: (A,0), (A|B,0), (A|~B,0), (0,1s)
  - s4..s7: (A,A&~B), (A|B,A&~B), (A,~B), (A&~B,1s)
  - s8..s11: (A,A&B), (A,B), (A|~B,A&B), (A&B,1s)
  - s12..s15: (A,A), (A|B,A), (A|~B,A), (A,1s)
- Widths: each slice sum is SLICE+1 bits. The MSB is the slice carry.

Optional Feature:
- Macro: ULA_FLAGS_EN.
- When defined, two extra outputs are added, registered with f and reset to 0:
  - zero (1 bit): f==0.
  - ovf (1 bit): signed overflow = carry into MSB XOR carry out of MSB, taken from the last slice; 0 when m=1.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package ula_pkg:
  - state enum (IDLE, CALC, DONE).
  - named select constants: S_SOMA=4'd9, S_SUB=4'd6, S_INC=4'd0, S_XOR=4'd6 with m=1.
- Sub-module ula_fatia #(SLICE):
  - Combinational slice ALU: x, y, s, m, c_in -> f, c_out, ovf.
  - The top instantiates it once and muxes the slice operands by idx.

Test Plan:
- WIDTH=8, SLICE=4; m=0, s=9, c_in=0, a=100, b=27 -> f=127, c_out=0, out_valid exactly 2 clocks after accept.
- Same config, a=200, b=100 -> f=44, c_out=1. Then m=0, s=6, c_in=1, a=4, b=3 -> f=1, c_out=1. Then a=b=55, s=6, c_in=0 -> f=255, a_eq_b=1, c_out=0.
- m=1, s=6, a=0xF0, b=0x3C -> f=0xCC, c_out=0. Sweep all 32 (m, s) at c_in=0/1 with a=4, b=3 against the table above.
- Backpressure: hold out_ready=0 for 5 cycles while pulsing in_valid with other operands -> out_valid stays 1, f unchanged, in_ready=0, new operands not taken.
- WIDTH=16, SLICE=4; m=0, s=0, c_in=1, a=0x0FFF -> f=0x1000, c_out=0, latency 4. Carry must ripple across 3 slice boundaries.
- Drop rst_n during CALC -> out_valid=0, f=0, in_ready=1 immediately. The next operation completes correctly. With ULA_FLAGS_EN: 127+1 (s=9) gives ovf=1, zero=0; 255+1 gives f=0, zero=1, c_out=1.
